// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO drain stage with 3-entry latency buffer, valid/ready stream and packet framing
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  Read_enable,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] entries [0:2];
  logic [1:0]            head;
  logic [1:0]            tail;
  logic [1:0]            occ;
  logic                  inflight;
  logic [IDX_W-1:0]      word_idx;
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts words already held plus the one still in flight from the FIFO.
  assign Read_enable = !empty && (({1'b0, occ} + {2'b00, inflight}) < 3'd3);

  assign push      = inflight;
  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? entries[head] : '0;
  assign out_last  = out_valid && (word_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) entries[i] <= '0;
      head      <= 2'd0;
      tail      <= 2'd0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      word_idx  <= '0;
      pkt_count <= '0;
    end else begin
      inflight <= Read_enable;
      if (push) begin
        entries[tail] <= data_out;
        tail          <= next_ptr(tail);
      end
      if (pop) begin
        head     <= next_ptr(head);
        word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + 1'b1;
        if (out_last) pkt_count <= pkt_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader with FIFO and stream reference model
module tb_fifo_stream_reader;

  localparam int PKT_LEN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        empty;
  logic [31:0] data_out;
  logic        Read_enable;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] pkt_count;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(32), .PKT_LEN(PKT_LEN), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .empty(empty), .data_out(data_out),
    .Read_enable(Read_enable), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .pkt_count(pkt_count)
  );

  // FIFO model: one-cycle read latency, flushed by the shared reset.
  logic [31:0] mem [0:4095];
  int wr_count = 0;
  int rd_count = 0;
  assign empty = (wr_count == rd_count);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= wr_count;
      data_out <= '0;
    end else if (Read_enable && !empty) begin
      data_out <= mem[rd_count % 4096];
      rd_count <= rd_count + 1;
    end
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  int pops = 0;
  int issued = 0;
  logic prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  logic prev_last = 1'b0;

  typedef struct {
    logic        ready;
    logic        exp_re;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_last;
    logic [15:0] exp_pkt;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_count % 4096] = w;
    wr_count++;
    exp_q.push_back(w);
  endtask

  task automatic clear_model();
    exp_q.delete();
    pops = 0;
    issued = 0;
    prev_hold = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    clear_model();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One cycle checked against the stream rules: order, framing, credit, stability.
  task automatic step();
    logic [31:0] w;
    #1;
    chk("re_while_empty", {63'd0, Read_enable && empty}, 64'd0);
    if (prev_hold) begin
      chk("hold_data", {32'd0, out_data}, {32'd0, prev_data});
      chk("hold_last", {63'd0, out_last}, {63'd0, prev_last});
    end
    chk("pkt_count", {48'd0, pkt_count}, 64'((pops / PKT_LEN) % 65536));
    if (Read_enable) issued++;
    if (issued - pops > 3) chk("credit_overflow", 64'(issued - pops), 64'd3);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 64'd1, 64'd0);
      end else begin
        w = exp_q.pop_front();
        chk("word_order", {32'd0, out_data}, {32'd0, w});
      end
      chk("last_flag", {63'd0, out_last}, {63'd0, (pops % PKT_LEN) == PKT_LEN - 1});
      pops++;
    end
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
    prev_last = out_last;
    @(negedge clk);
  endtask

  initial begin
    int budget;
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'd2, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'd3, 1'b0, 16'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'd4, 1'b1, 16'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'd5, 1'b0, 16'd1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'd6, 1'b0, 16'd1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'd7, 1'b0, 16'd1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'd8, 1'b1, 16'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 16'd2};

    reset = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_re", {63'd0, Read_enable}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    chk("rst_last", {63'd0, out_last}, 64'd0);
    chk("rst_pkt", {48'd0, pkt_count}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single word: first-word latency of two cycles.
    do_reset();
    out_ready = 1'b1;
    push_word(32'hA5A50001);
    #1;
    chk("single_re_c0", {63'd0, Read_enable}, 64'd1);
    @(negedge clk); #1;
    chk("single_re_c1", {63'd0, Read_enable}, 64'd0);
    chk("single_valid_c1", {63'd0, out_valid}, 64'd0);
    @(negedge clk); #1;
    chk("single_valid_c2", {63'd0, out_valid}, 64'd1);
    chk("single_data_c2", {32'd0, out_data}, 64'hA5A50001);
    chk("single_last_c2", {63'd0, out_last}, 64'd0);
    @(negedge clk);

    // Streaming 8 words, cycle-exact table.
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(32'(i));
    for (int i = 0; i < 11; i++) begin
      out_ready = vecs[i].ready;
      #1;
      chk($sformatf("stream_re_c%0d", i), {63'd0, Read_enable}, {63'd0, vecs[i].exp_re});
      chk($sformatf("stream_valid_c%0d", i), {63'd0, out_valid}, {63'd0, vecs[i].exp_valid});
      chk($sformatf("stream_data_c%0d", i), {32'd0, out_data}, {32'd0, vecs[i].exp_data});
      chk($sformatf("stream_last_c%0d", i), {63'd0, out_last}, {63'd0, vecs[i].exp_last});
      chk($sformatf("stream_pkt_c%0d", i), {48'd0, pkt_count}, {48'd0, vecs[i].exp_pkt});
      @(negedge clk);
    end

    // Backpressure: 6 words, consumer stalled.
    do_reset();
    for (int i = 1; i <= 6; i++) push_word(32'h100 + 32'(i));
    for (int c = 0; c < 12; c++) begin
      if (c >= 2) begin
        #1;
        chk("bp_held_word1", {32'd0, out_data}, 64'h101);
        #1;
        step();
      end else begin
        step();
      end
    end
    chk("bp_read_pulses", 64'(issued), 64'd3);
    out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 40) begin
      step();
      budget++;
    end
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_pops", 64'(pops), 64'd6);
    step();
    chk("bp_no_extra", 64'(pops), 64'd6);

    // Empty FIFO stays idle.
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("idle_re", {63'd0, Read_enable}, 64'd0);
      chk("idle_valid", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
    end

    // Asynchronous reset mid-stream.
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) push_word(32'h200 + 32'(i));
    for (int c = 0; c < 7; c++) step();
    #1;
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("pre_rst_pkt", {48'd0, pkt_count}, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_re", {63'd0, Read_enable}, 64'd0);
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_data", {32'd0, out_data}, 64'd0);
    chk("async_rst_last", {63'd0, out_last}, 64'd0);
    chk("async_rst_pkt", {48'd0, pkt_count}, 64'd0);
    clear_model();
    @(negedge clk);
    reset = 1'b1;

    // Reset after two pops restarts framing.
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(32'h300 + 32'(i));
    budget = 0;
    while (pops < 2 && budget < 20) begin
      step();
      budget++;
    end
    chk("midpkt_two_pops", 64'(pops), 64'd2);
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(32'h400 + 32'(i));
    for (int c = 0; c < 12; c++) step();
    chk("midpkt_pops", 64'(pops), 64'd8);
    chk("midpkt_pkt", {48'd0, pkt_count}, 64'd2);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) push_word($urandom);
      step();
    end
    out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      step();
      budget++;
    end
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
